// File: rtl/seq_divider.sv
// Multi-cycle 32-bit signed restoring divider with a start/ready handshake.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and completes straight from IDLE.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             exception
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] ITER  = 3'd2;
  localparam logic [2:0] FIX   = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dvs_reg;
  logic [WIDTH-1:0] mag_dvs;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   rem_acc;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             div_zero;
  logic             overflow;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  // The partial remainder never exceeds |divisor| <= 2^31, so the 33-bit trial's MSB is a reliable borrow.
  always_comb begin
    shifted  = (rem_acc << 1) | {{WIDTH{1'b0}}, quo[WIDTH-1]};
    trial    = shifted - {1'b0, mag_dvs};
    div_zero = (dvs_reg == '0);
    overflow = (dvd_reg == MIN_NEG) && (dvs_reg == '1);
    quo_fix  = sign_q ? (~quo + 1'b1) : quo;
    rem_fix  = sign_r ? (~rem_acc[WIDTH-1:0] + 1'b1) : rem_acc[WIDTH-1:0];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      mag_dvs   <= '0;
      quo       <= '0;
      rem_acc   <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
      busy      <= 1'b0;
      ready     <= 1'b0;
      result    <= '0;
      remainder <= '0;
      exception <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_reg <= dividend;
            dvs_reg <= divisor;
`ifdef DIV_ZERO_FAST_EN
            if (divisor == '0) begin
              result    <= '0;
              remainder <= dividend;
              exception <= 1'b1;
              state     <= DONE;
            end else begin
              state <= SETUP;
            end
`else
            state <= SETUP;
`endif
          end
        end
        SETUP: begin
          sign_q  <= dvd_reg[WIDTH-1] ^ dvs_reg[WIDTH-1];
          sign_r  <= dvd_reg[WIDTH-1];
          quo     <= dvd_reg[WIDTH-1] ? (~dvd_reg + 1'b1) : dvd_reg;
          mag_dvs <= dvs_reg[WIDTH-1] ? (~dvs_reg + 1'b1) : dvs_reg;
          rem_acc <= '0;
          cnt     <= '0;
          busy    <= 1'b1;
          state   <= ITER;
        end
        ITER: begin
          if (!trial[WIDTH]) begin
            rem_acc <= trial;
            quo     <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem_acc <= shifted;
            quo     <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // A zero divisor runs the full loop but its quotient bits are meaningless, so outputs are forced.
          exception <= div_zero | overflow;
          if (div_zero) begin
            result    <= '0;
            remainder <= dvd_reg;
          end else if (overflow) begin
            result    <= MIN_NEG;
            remainder <= '0;
          end else begin
            result    <= quo_fix;
            remainder <= rem_fix;
          end
          state <= DONE;
        end
        DONE: begin
          ready <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against a plain-arithmetic signed division model.
module tb_seq_divider;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        ready;
  logic [31:0] result;
  logic [31:0] remainder;
  logic        exception;

  int tests_run = 0;
  int tests_failed = 0;

  seq_divider #(.WIDTH(32), .CNT_W(6)) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .ready(ready),
    .result(result),
    .remainder(remainder),
    .exception(exception)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reference: 64-bit signed arithmetic truncates toward zero and gives the remainder the dividend's sign.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r, output logic e);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'd0;
      r = a;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
      e = 1'b1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      e = 1'b0;
    end
  endfunction

  // One division; ignore_at >= 2 pulses a competing 9/3 start sampled on edge t0+ignore_at.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input int ignore_at);
    logic [31:0] exp_q;
    logic [31:0] exp_r;
    logic        exp_e;
    int          exp_lat;
    int          exp_busy;
    int          busy_cycles;
    int          ready_at;
    model(a, b, exp_q, exp_r, exp_e);
    exp_lat  = 35;
    exp_busy = 34;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) begin
      exp_lat  = 1;
      exp_busy = 0;
    end
`endif
    @(negedge clock);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clock);
    #1;
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    busy_cycles = 0;
    ready_at    = -1;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock);
      #1;
      if (busy) busy_cycles++;
      if (ready) begin
        ready_at = k;
        break;
      end
      if (k == ignore_at - 1) begin
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    checkOutput("latency", 32'(ready_at), 32'(exp_lat));
    checkOutput("busy_cycles", 32'(busy_cycles), 32'(exp_busy));
    checkOutput("result", result, exp_q);
    checkOutput("remainder", remainder, exp_r);
    checkOutput("exception", {31'd0, exception}, {31'd0, exp_e});
    @(posedge clock);
    #1;
    checkOutput("ready_pulse", {31'd0, ready}, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("result_held", result, exp_q);
    checkOutput("remainder_held", remainder, exp_r);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          ready_seen;
    int          busy_seen;

    #1 reset = 1'b1;
    #1;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_ready", {31'd0, ready}, 32'd0);
    checkOutput("reset_exception", {31'd0, exception}, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    checkOutput("reset_remainder", remainder, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(32'd100, 32'd7, -1);
    applyStimulus(32'hFFFF_FF9C, 32'd7, -1);
    applyStimulus(32'd100, 32'hFFFF_FFF9, -1);
    applyStimulus(32'hFFFF_FF9C, 32'hFFFF_FFF9, -1);
    applyStimulus(32'd7, 32'd0, -1);
    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, -1);
    applyStimulus(32'd0, 32'd5, -1);
    applyStimulus(32'h8000_0000, 32'd1, -1);
    applyStimulus(32'h7FFF_FFFF, 32'h8000_0000, -1);
    applyStimulus(32'h8000_0000, 32'h8000_0000, -1);
    applyStimulus(32'h8000_0000, 32'd0, -1);
    applyStimulus(32'd50, 32'd5, 10);

    // Reset in the middle of a 50/5 run must clear everything and produce no ready.
    @(negedge clock);
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
    checkOutput("midreset_ready", {31'd0, ready}, 32'd0);
    checkOutput("midreset_result", result, 32'd0);
    checkOutput("midreset_remainder", remainder, 32'd0);
    checkOutput("midreset_exception", {31'd0, exception}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    ready_seen = 0;
    busy_seen  = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (ready) ready_seen++;
      if (busy) busy_seen++;
    end
    checkOutput("no_ready_after_reset", 32'(ready_seen), 32'd0);
    checkOutput("no_busy_after_reset", 32'(busy_seen), 32'd0);
    applyStimulus(32'd9, 32'd3, -1);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'd0;
      if ($urandom_range(0, 9) == 0) begin
        ra = 32'h8000_0000;
        rb = 32'hFFFF_FFFF;
      end
      applyStimulus(ra, rb, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
